panda_risc_v_dsptc_queue: RTL and testbench

Parametrised dispatch queue for the panda_risc_v pipeline, sitting between the decoder and the execution units. It buffers decoded instructions in an in-order FIFO of configurable depth and issues the head entry to one of CH_N execution channels over valid/ready. Issue is gated by RAW/WAW hazard flags from the dependency checker. It also supports flush, software-reset clear, and dispatch/stall/error statistics.

---
 rtl/panda_risc_v_dsptc_queue.sv | 167 ++++++++++++++++
 tb/tb_panda_risc_v_dsptc_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_risc_v_dsptc_queue.sv
// Dispatch queue: in-order FIFO of decoded instructions. The head entry is issued to one of
//   CH_N execution channels, gated by RAW/WAW hazard flags from the dependency checker.
// Latency: an entry pushed at edge N can first be issued in cycle N+1. There is no bypass.
// Backpressure: s_dcd_ready drops when the queue is full or during flush/soft reset. It
//   ignores same-cycle pops. m_valid is not sticky: a hazard, flush or soft reset withdraws it.
// Ports: clk/sys_resetn (async, active-low), sys_reset_req (soft clear), flush_req;
//   s_dcd_* decoder push side; raw_dpc_check_*_id out / *_dpc in for hazard lookup;
//   m_payload/m_valid/m_ready channel issue side; fifo_cnt plus dispatch/stall/error counters.
module panda_risc_v_dsptc_queue #(
  parameter int CH_N             = 6,
  parameter int PAYLOAD_W        = 96,
  parameter int FIFO_DEPTH       = 4,
  parameter int simulation_delay = 1
) (
  input  logic                              clk,
  input  logic                              sys_resetn,
  input  logic                              sys_reset_req,
  input  logic                              flush_req,
  input  logic [PAYLOAD_W-1:0]              s_dcd_payload,
  input  logic [$clog2(CH_N)-1:0]           s_dcd_unit_id,
  input  logic [4:0]                        s_dcd_rs1_id,
  input  logic [4:0]                        s_dcd_rs2_id,
  input  logic [4:0]                        s_dcd_rd_id,
  input  logic [2:0]                        s_dcd_reg_vld,
  input  logic                              s_dcd_valid,
  output logic                              s_dcd_ready,
  output logic [4:0]                        raw_dpc_check_rs1_id,
  output logic [4:0]                        raw_dpc_check_rs2_id,
  output logic [4:0]                        raw_dpc_check_rd_id,
  input  logic                              rs1_raw_dpc,
  input  logic                              rs2_raw_dpc,
  input  logic                              rd_waw_dpc,
  output logic [PAYLOAD_W-1:0]              m_payload,
  output logic [CH_N-1:0]                   m_valid,
  input  logic [CH_N-1:0]                   m_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_cnt,
  output logic [31:0]                       dsptc_cnt,
  output logic [31:0]                       stall_cnt,
  output logic [15:0]                       unit_err_cnt
);

  localparam int UW = $clog2(CH_N);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Elaboration-time sanity check of the parameter set.
  if (CH_N < 2 || CH_N > 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      simulation_delay < 0) begin : g_param_err
    $error("panda_risc_v_dsptc_queue: illegal parameter set");
  end

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [UW-1:0]        unit_id;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [2:0]           vld;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] wptr_q,  wptr_d;
  logic [31:0]   dsptc_q, dsptc_d;
  logic [31:0]   stall_q, stall_d;
  logic [15:0]   err_q,   err_d;

  entry_t head;
  logic   nonempty, ctrl_blk, unit_ok, hazard, issue_ok;
  logic   push, pop_ok, discard, stall_inc;

  assign head     = mem_q[rptr_q];
  assign nonempty = (cnt_q != '0);
  assign ctrl_blk = flush_req | sys_reset_req;
  assign unit_ok  = (int'(head.unit_id) < CH_N);
  assign hazard   = (head.vld[0] & rs1_raw_dpc) | (head.vld[1] & rs2_raw_dpc) |
                    (head.vld[2] & rd_waw_dpc);
  assign issue_ok = nonempty & unit_ok & ~hazard & ~ctrl_blk;

  // Ready is qualified by the reset pin so it reads 0 throughout reset.
  assign s_dcd_ready = sys_resetn & (cnt_q != CW'(FIFO_DEPTH)) & ~ctrl_blk;
  assign push        = s_dcd_valid & s_dcd_ready;

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < CH_N; i++) begin
      m_valid[i] = issue_ok & (int'(head.unit_id) == i);
    end
  end

  assign pop_ok    = |(m_valid & m_ready);
  // An out-of-range unit_id can never handshake, so it is dropped to unblock the queue.
  assign discard   = nonempty & ~unit_ok & ~ctrl_blk;
  assign stall_inc = nonempty & unit_ok & hazard;

  assign raw_dpc_check_rs1_id = nonempty ? head.rs1 : 5'd0;
  assign raw_dpc_check_rs2_id = nonempty ? head.rs2 : 5'd0;
  assign raw_dpc_check_rd_id  = nonempty ? head.rd  : 5'd0;
  assign m_payload            = nonempty ? head.payload : '0;

  assign fifo_cnt     = cnt_q;
  assign dsptc_cnt    = dsptc_q;
  assign stall_cnt    = stall_q;
  assign unit_err_cnt = err_q;

  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    dsptc_d = dsptc_q;
    stall_d = stall_q;
    err_d   = err_q;
    if (push) begin
      mem_d[wptr_q] = '{payload: s_dcd_payload, unit_id: s_dcd_unit_id, rs1: s_dcd_rs1_id,
                        rs2: s_dcd_rs2_id, rd: s_dcd_rd_id, vld: s_dcd_reg_vld};
    end
    if (sys_reset_req) begin
      cnt_d   = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      dsptc_d = '0;
      stall_d = '0;
      err_d   = '0;
    end else begin
      if (flush_req) begin
        cnt_d  = '0;
        rptr_d = '0;
        wptr_d = '0;
      end else begin
        // Pointers wrap naturally since the depth is a power of two.
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop_ok | discard);
        cnt_d  = cnt_q + CW'(push) - CW'(pop_ok | discard);
      end
      if (pop_ok)                     dsptc_d = dsptc_q + 32'd1;
      if (stall_inc && stall_q != '1) stall_d = stall_q + 32'd1;
      if (discard && err_q != '1)     err_d   = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      dsptc_q <= '0;
      stall_q <= '0;
      err_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      dsptc_q <= dsptc_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  // Instruction storage carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_panda_risc_v_dsptc_queue.sv
module tb_panda_risc_v_dsptc_queue;
  localparam int CH_N  = 6;
  localparam int PLW   = 96;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           sys_resetn, sys_reset_req, flush_req;
  logic [PLW-1:0] s_dcd_payload;
  logic [2:0]     s_dcd_unit_id;
  logic [4:0]     s_dcd_rs1_id, s_dcd_rs2_id, s_dcd_rd_id;
  logic [2:0]     s_dcd_reg_vld;
  logic           s_dcd_valid, s_dcd_ready;
  logic [4:0]     raw_dpc_check_rs1_id, raw_dpc_check_rs2_id, raw_dpc_check_rd_id;
  logic           rs1_raw_dpc, rs2_raw_dpc, rd_waw_dpc;
  logic [PLW-1:0] m_payload;
  logic [CH_N-1:0] m_valid, m_ready;
  logic [2:0]     fifo_cnt;
  logic [31:0]    dsptc_cnt, stall_cnt;
  logic [15:0]    unit_err_cnt;

  panda_risc_v_dsptc_queue #(.CH_N(CH_N), .PAYLOAD_W(PLW), .FIFO_DEPTH(DEPTH), .simulation_delay(1)) dut (
    .clk(clk), .sys_resetn(sys_resetn), .sys_reset_req(sys_reset_req), .flush_req(flush_req),
    .s_dcd_payload(s_dcd_payload), .s_dcd_unit_id(s_dcd_unit_id),
    .s_dcd_rs1_id(s_dcd_rs1_id), .s_dcd_rs2_id(s_dcd_rs2_id), .s_dcd_rd_id(s_dcd_rd_id),
    .s_dcd_reg_vld(s_dcd_reg_vld), .s_dcd_valid(s_dcd_valid), .s_dcd_ready(s_dcd_ready),
    .raw_dpc_check_rs1_id(raw_dpc_check_rs1_id), .raw_dpc_check_rs2_id(raw_dpc_check_rs2_id),
    .raw_dpc_check_rd_id(raw_dpc_check_rd_id),
    .rs1_raw_dpc(rs1_raw_dpc), .rs2_raw_dpc(rs2_raw_dpc), .rd_waw_dpc(rd_waw_dpc),
    .m_payload(m_payload), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_cnt(fifo_cnt), .dsptc_cnt(dsptc_cnt), .stall_cnt(stall_cnt), .unit_err_cnt(unit_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of instruction records plus plain integer counters.
  typedef struct {
    logic [PLW-1:0] payload;
    int             unit;
    int             rs1, rs2, rd;
    logic [2:0]     vld;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_dsptc = 0, m_stall = 0, m_err = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit stats);
    mq.delete();
    if (stats) begin
      m_dsptc = 0; m_stall = 0; m_err = 0;
    end
  endtask

  // Compare every output against the model for the current cycle, then advance the model.
  task automatic model_step();
    ent_t            h;
    ent_t            n;
    bit              ne, ctrl, hz, exp_rdy, popped, discard;
    logic [CH_N-1:0] ev;
    ne = (mq.size() > 0);
    ctrl = flush_req | sys_reset_req;
    exp_rdy = (mq.size() < DEPTH) && !ctrl;
    ev = '0;
    hz = 1'b0;
    h = '{payload: '0, unit: 0, rs1: 0, rs2: 0, rd: 0, vld: 3'b000};
    if (ne) begin
      h = mq[0];
      hz = (h.vld[0] && rs1_raw_dpc) || (h.vld[1] && rs2_raw_dpc) || (h.vld[2] && rd_waw_dpc);
      if (h.unit < CH_N && !hz && !ctrl) ev[h.unit] = 1'b1;
    end
    chk("s_dcd_ready", s_dcd_ready, exp_rdy);
    chk("m_valid", m_valid, ev);
    chk("chk_rs1_id", raw_dpc_check_rs1_id, h.rs1);
    chk("chk_rs2_id", raw_dpc_check_rs2_id, h.rs2);
    chk("chk_rd_id", raw_dpc_check_rd_id, h.rd);
    chk("m_payload", m_payload, h.payload);
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("dsptc_cnt", dsptc_cnt, m_dsptc);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("unit_err_cnt", unit_err_cnt, m_err);
    popped  = ((ev & m_ready) != '0);
    discard = ne && (h.unit >= CH_N) && !ctrl;
    if (sys_reset_req) begin
      model_clear(1'b1);
    end else begin
      if (ne && h.unit < CH_N && hz && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (popped) m_dsptc++;
      if (discard && m_err != 32'h0000_FFFF) m_err++;
      if (flush_req) begin
        model_clear(1'b0);
      end else begin
        if (popped || discard) void'(mq.pop_front());
        if (s_dcd_valid && exp_rdy) begin
          n.payload = s_dcd_payload; n.unit = int'(s_dcd_unit_id);
          n.rs1 = int'(s_dcd_rs1_id); n.rs2 = int'(s_dcd_rs2_id); n.rd = int'(s_dcd_rd_id);
          n.vld = s_dcd_reg_vld;
          mq.push_back(n);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int u, input int r1, input int r2, input int rd,
                       input logic [2:0] vl);
    s_dcd_valid   = v;
    s_dcd_unit_id = 3'(u);
    s_dcd_rs1_id  = 5'(r1);
    s_dcd_rs2_id  = 5'(r2);
    s_dcd_rd_id   = 5'(rd);
    s_dcd_reg_vld = vl;
    s_dcd_payload = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    sys_resetn = 1'b0; sys_reset_req = 1'b0; flush_req = 1'b0;
    rs1_raw_dpc = 1'b0; rs2_raw_dpc = 1'b0; rd_waw_dpc = 1'b0;
    m_ready = '0;
    drive(0, 0, 0, 0, 0, 3'b000);

    // Reset values
    #2;
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ready", s_dcd_ready, 0);
    chk("rst_dsptc", dsptc_cnt, 0);
    chk("rst_rs1_id", raw_dpc_check_rs1_id, 0);
    #10 sys_resetn = 1'b1;
    @(posedge clk); #1;

    // Fill and drain with every channel ready
    m_ready = '1;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, i + 1, i + 2, i + 3, 3'b000);
      tick();
    end
    drive(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) tick();
    chk("fill_dsptc", dsptc_cnt, 4);
    chk("fill_fifo_cnt", fifo_cnt, 0);

    // Full back-pressure
    m_ready = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1, i, 1, 2, 3, 3'b000);
      tick();
    end
    chk("full_ready", s_dcd_ready, 0);
    chk("full_cnt", fifo_cnt, 4);
    m_ready = '1;
    drive(1, 5, 0, 0, 0, 3'b000);
    tick();
    chk("full_pop_only", fifo_cnt, 3);
    drive(0, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) tick();

    // Software reset clear
    sys_reset_req = 1'b1;
    tick();
    sys_reset_req = 1'b0;
    chk("srst_dsptc", dsptc_cnt, 0);
    chk("srst_cnt", fifo_cnt, 0);

    // Hazard stall on rs1
    m_ready = '1;
    drive(1, 2, 5, 0, 0, 3'b001);
    tick();
    drive(0, 0, 0, 0, 0, 3'b000);
    rs1_raw_dpc = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("haz_m_valid", m_valid, 0);
    chk("haz_rs1_id", raw_dpc_check_rs1_id, 5);
    chk("haz_stall_cnt", stall_cnt, 3);
    rs1_raw_dpc = 1'b0;
    #1 chk("haz_release", m_valid, 6'b000100);
    tick();
    chk("haz_issued", dsptc_cnt, 1);

    // Flush mid-stream
    m_ready = '0;
    for (int i = 0; i < 3; i++) begin
      drive(1, i, 0, 0, 0, 3'b000);
      tick();
    end
    drive(0, 0, 0, 0, 0, 3'b000);
    m_ready = '1;
    flush_req = 1'b1;
    #1 chk("flush_no_valid", m_valid, 0);
    tick();
    flush_req = 1'b0;
    chk("flush_cnt", fifo_cnt, 0);
    chk("flush_dsptc", dsptc_cnt, 1);

    // Out-of-range unit id
    drive(1, 7, 0, 0, 0, 3'b000);
    tick();
    drive(0, 0, 0, 0, 0, 3'b000);
    chk("bad_no_valid", m_valid, 0);
    chk("bad_queued", fifo_cnt, 1);
    tick();
    chk("bad_gone", fifo_cnt, 0);
    chk("bad_err_cnt", unit_err_cnt, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom_range(0, 7), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), 3'($urandom));
      rs1_raw_dpc   = ($urandom_range(0, 3) == 0);
      rs2_raw_dpc   = ($urandom_range(0, 3) == 0);
      rd_waw_dpc    = ($urandom_range(0, 3) == 0);
      m_ready       = CH_N'($urandom);
      flush_req     = ($urandom_range(0, 31) == 0);
      sys_reset_req = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush_req = 1'b0; sys_reset_req = 1'b0;
    rs1_raw_dpc = 1'b0; rs2_raw_dpc = 1'b0; rd_waw_dpc = 1'b0;

    // Asynchronous reset with entries queued
    m_ready = '0;
    for (int i = 0; i < 2; i++) begin
      drive(1, i, 7, 8, 9, 3'b111);
      tick();
    end
    drive(0, 0, 0, 0, 0, 3'b000);
    #2 sys_resetn = 1'b0;
    #1;
    chk("arst_fifo_cnt", fifo_cnt, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_ready", s_dcd_ready, 0);
    chk("arst_dsptc", dsptc_cnt, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_err", unit_err_cnt, 0);
    chk("arst_rd_id", raw_dpc_check_rd_id, 0);
    model_clear(1'b1);
    @(negedge clk); #2 sys_resetn = 1'b1;
    @(posedge clk); #1;

    // Software reset after building up state
    m_ready = '1;
    rd_waw_dpc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, (i == 2) ? 6 : i, 0, 0, 4, 3'b100);
      tick();
    end
    rd_waw_dpc = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 3'b000);
    sys_reset_req = 1'b1;
    tick();
    sys_reset_req = 1'b0;
    chk("srst2_cnt", fifo_cnt, 0);
    chk("srst2_dsptc", dsptc_cnt, 0);
    chk("srst2_stall", stall_cnt, 0);
    chk("srst2_err", unit_err_cnt, 0);
    for (int i = 0; i < 2; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
